// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial subtractor, diff = a - b - bin, one bit per clock, LSB first.
// Operands are captured on an accepted start; the result appears WIDTH edges later with a
// one-cycle done pulse. Trades latency (WIDTH+1 cycles per result) for a 1-bit datapath.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only when not busy (IDLE or DONE)
//   a, b   minuend / subtrahend, captured on accepted start
//   bin    borrow-in, captured on accepted start
//   busy   high while shifting
//   done   single-cycle pulse, diff/bout valid
//   diff   result, held until the next completion
//   bout   borrow-out (a < b + bin, unsigned), held like diff
//   ovf    signed overflow, held like diff (only when SERIAL_SUB_OVF_EN is defined)
//
// Configuration macro: SERIAL_SUB_OVF_EN adds the ovf output and its logic.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sa, sa_d;
    logic [WIDTH-1:0] sb, sb_d;
    logic [WIDTH-1:0] partial, partial_d;
    logic [WIDTH-1:0] diff_d;
    logic             br, br_d;
    logic             bout_d;
    logic             d;
    logic [CW-1:0]    cnt, cnt_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_d;
`endif

    // Next-state and datapath update
    always_comb begin
        state_d   = state;
        sa_d      = sa;
        sb_d      = sb;
        br_d      = br;
        cnt_d     = cnt;
        partial_d = partial;
        diff_d    = diff;
        bout_d    = bout;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d     = ovf;
`endif
        d         = sa[0] ^ sb[0] ^ br;

        case (state)
            IDLE, DONE: begin
                // DONE always exits; a start there chains the next operation directly
                if (start) begin
                    sa_d      = a;
                    sb_d      = b;
                    br_d      = bin;
                    cnt_d     = '0;
                    partial_d = '0;
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                br_d      = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
                partial_d = {d, partial[WIDTH-1:1]};
                sa_d      = sa >> 1;
                sb_d      = sb >> 1;
                cnt_d     = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    diff_d  = partial_d;
                    bout_d  = br_d;
`ifdef SERIAL_SUB_OVF_EN
                    // On the last step sa[0]/sb[0] hold the operand MSBs and d is the result MSB
                    ovf_d   = (sa[0] ^ sb[0]) & (d ^ sa[0]);
`endif
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sa      <= '0;
            sb      <= '0;
            br      <= 1'b0;
            cnt     <= '0;
            partial <= '0;
            diff    <= '0;
            bout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            sa      <= sa_d;
            sb      <= sb_d;
            br      <= br_d;
            cnt     <= cnt_d;
            partial <= partial_d;
            diff    <= diff_d;
            bout    <= bout_d;
            busy    <= (state_d == SHIFT);
            done    <= (state_d == DONE);
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed bench for serial_subtractor (WIDTH=4) with a
// transaction-level reference model checked every cycle plus literal expectations.
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ovf_of(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W-1:0] r;
        r = x - y - W'(c);
        return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    // Reference model: an accepted operation completes WIDTH edges later
    int           m_cnt = 0;
    logic [W:0]   m_res = '0;
    logic         m_ovf = 1'b0;
    logic         exp_done = 1'b0;
    logic [W-1:0] exp_diff = '0;
    logic         exp_bout = 1'b0;
    logic         exp_ovf = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt    <= 0;
            exp_done <= 1'b0;
            exp_diff <= '0;
            exp_bout <= 1'b0;
            exp_ovf  <= 1'b0;
        end else begin
            exp_done <= 1'b0;
            if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end else if (m_cnt == 1) begin
                m_cnt    <= 0;
                exp_done <= 1'b1;
                exp_bout <= m_res[W];
                exp_diff <= m_res[W-1:0];
                exp_ovf  <= m_ovf;
            end else if (start) begin
                m_cnt <= W;
                m_res <= {1'b0, a} - {1'b0, b} - (W+1)'(bin);
                m_ovf <= ovf_of(a, b, bin);
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", int'(busy), int'(m_cnt != 0));
            check("cyc_done", int'(done), int'(exp_done));
            check("cyc_diff", int'(diff), int'(exp_diff));
            check("cyc_bout", int'(bout), int'(exp_bout));
`ifdef SERIAL_SUB_OVF_EN
            check("cyc_ovf", int'(ovf), int'(exp_ovf));
`endif
        end
    end

    // Issue one operation and wait (bounded) for its done cycle
    task automatic run_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xc, input bit scramble,
                          input int exp_d, input int exp_bo, input int exp_ovf_v);
        int  bc;
        bit  got;
        @(posedge clk);
        #1;
        a = xa; b = xb; bin = xc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bc = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) bc++;
                if (scramble) begin
                    a   = W'($urandom);
                    b   = W'($urandom);
                    bin = 1'($urandom);
                end
            end
        end
        if (!got) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            check({name, "_diff"}, int'(diff), exp_d);
            check({name, "_bout"}, int'(bout), exp_bo);
            check({name, "_busycyc"}, bc, W);
`ifdef SERIAL_SUB_OVF_EN
            check({name, "_ovf"}, int'(ovf), exp_ovf_v);
`else
            if (exp_ovf_v < 0) check({name, "_ovfarg"}, exp_ovf_v, 0);
`endif
        end
    endtask

    initial begin
        int idx[3];
        int n;
        int ndone;
        logic [W:0] e;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_bout", int'(bout), 0);
        chk_en = 1'b1;

        // Basic operations and corners
        run_op("t1_9m3", 4'd9, 4'd3, 1'b0, 1'b0, 6, 0, 0);
        run_op("t2_3m9", 4'd3, 4'd9, 1'b0, 1'b0, 10, 1, 0);
        run_op("t2_0m0b", 4'd0, 4'd0, 1'b1, 1'b0, 15, 1, 0);
        run_op("eq_bin", 4'd7, 4'd7, 1'b1, 1'b0, 15, 1, 0);
        run_op("ff_m0", 4'd15, 4'd0, 1'b0, 1'b0, 15, 0, 0);
        // Inputs change while shifting; in-flight result unaffected
        run_op("scramble", 4'd12, 4'd5, 1'b1, 1'b1, 6, 0, 1);

        // Start held high: back-to-back results every W+1 cycles
        @(posedge clk);
        #1;
        a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge clk);
            if (done) begin
                idx[n] = i;
                n++;
                check("b2b_diff", int'(diff), 3);
                check("b2b_bout", int'(bout), 0);
            end
        end
        check("b2b_count", n, 3);
        if (n == 3) begin
            check("b2b_gap1", idx[1] - idx[0], W + 1);
            check("b2b_gap2", idx[2] - idx[1], W + 1);
        end
        #1 start = 1'b0;
        repeat (8) @(negedge clk);

        // Reset on the second shift cycle aborts the operation
        @(posedge clk);
        #1;
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_diff", int'(diff), 0);
        check("abort_bout", int'(bout), 0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_nodone", ndone, 0);
        run_op("after_abort", 4'd7, 4'd2, 1'b0, 1'b0, 5, 0, 0);

`ifdef SERIAL_SUB_OVF_EN
        run_op("ovf_8m1", 4'd8, 4'd1, 1'b0, 1'b0, 7, 0, 1);
        run_op("ovf_7m1", 4'd7, 4'd1, 1'b0, 1'b0, 6, 0, 0);
`endif

        // Exhaustive sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    e = 5'(ia) - 5'(ib) - 5'(ic);
                    run_op("exh", W'(ia), W'(ib), 1'(ic), 1'b0,
                           int'(e[W-1:0]), int'(e[W]),
                           int'(ovf_of(W'(ia), W'(ib), 1'(ic))));
                end
            end
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
